// File: rtl/seq_serial_comparator.sv
// seq_serial_comparator: bit-serial magnitude comparator for two WIDTH-bit
// operands, unsigned or two's-complement signed, selected per operation.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - request; accepted in IDLE or DONE
//   sgn   - 1 = signed compare, 0 = unsigned; sampled with start
//   a, b  - WIDTH-bit operands; sampled with start
//   busy  - high while bit pairs are being scanned
//   done  - one-cycle pulse when L/E/G carry a new result
//   L/E/G - A < B, A == B, A > B; held until the next result or reset
//
// Build option: define SEQ_CMP_EARLY_EXIT_EN for an MSB-first scan that
// stops at the first differing bit. Without it, the scan is LSB-first with
// fixed latency. Both builds produce identical L/E/G for every input.
module seq_serial_comparator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             L,
    output logic             E,
    output logic             G
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] R_EQ = 2'd0;
    localparam logic [1:0] R_LT = 2'd1;
    localparam logic [1:0] R_GT = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       res_q, res_d;
    logic             busy_q, done_q, l_q, e_q, g_q;

    logic             bit_a, bit_b, differ, is_sign, is_last, stop, load;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    // MSB-first: the sign bit is the first one examined.
    assign bit_a   = a_q[WIDTH-1];
    assign bit_b   = b_q[WIDTH-1];
    assign is_sign = (cnt_q == '0);
`else
    // LSB-first: the sign bit is the last one examined.
    assign bit_a   = a_q[0];
    assign bit_b   = b_q[0];
    assign is_sign = (cnt_q == LAST);
`endif

    assign differ  = bit_a ^ bit_b;
    assign is_last = (cnt_q == LAST);

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign stop = differ | is_last;
`else
    assign stop = is_last;
`endif

    assign load = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (load) begin
            state_d = S_SHIFT;
            a_d     = a;
            b_d     = b;
            sgn_d   = sgn;
            cnt_d   = '0;
            res_d   = R_EQ;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // A set sign bit means a negative value in signed mode,
                    // so the magnitude decision flips there.
                    if (differ)
                        res_d = (bit_a ^ (sgn_q & is_sign)) ? R_GT : R_LT;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    a_d = a_q << 1;
                    b_d = b_q << 1;
`else
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
`endif
                    cnt_d = cnt_q + CW'(1);
                    if (stop)
                        state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= R_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= (state_d == S_SHIFT);
            // Results are published on the edge that leaves DONE, so a
            // back-to-back start never has to wait on the outputs.
            done_q  <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                l_q <= (res_q == R_LT);
                e_q <= (res_q == R_EQ);
                g_q <= (res_q == R_GT);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign L    = l_q;
    assign E    = e_q;
    assign G    = g_q;

endmodule

// File: tb/tb_seq_serial_comparator.sv
// tb_seq_serial_comparator: directed scoreboard bench for the serial
// comparator at WIDTH=32, in either scan build.
module tb_seq_serial_comparator;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, L, E, G;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int   when;
        logic l;
        logic e;
        logic g;
    } exp_t;

    exp_t q[$];

    seq_serial_comparator #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sgn  (sgn),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .L    (L),
        .E    (E),
        .G    (G)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int lat(logic [W-1:0] x, logic [W-1:0] y);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return (W - i) + 1;
        return W + 1;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        if (rst && done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cyc=%0d LEG=%b%b%b", cyc, L, E, G);
            end else begin
                exp_t x;
                x = q.pop_front();
                if (cyc != x.when || L != x.l || E != x.e || G != x.g) begin
                    failures++;
                    $display("FAIL result cyc=%0d LEG=%b%b%b want cyc=%0d LEG=%b%b%b",
                             cyc, L, E, G, x.when, x.l, x.e, x.g);
                end
            end
        end
    end

    task automatic chk(string name, logic act, logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, want);
        end
    endtask

    task automatic push(int s, logic [W-1:0] x, logic [W-1:0] y,
                        logic l, logic e, logic g);
        exp_t t;
        t.when = s + lat(x, y);
        t.l = l;
        t.e = e;
        t.g = g;
        q.push_back(t);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout pending=%0d", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(logic [W-1:0] x, logic [W-1:0] y, logic s_in,
                          logic l, logic e, logic g);
        int s;
        @(negedge clk);
        a = x;
        b = y;
        sgn = s_in;
        start = 1'b1;
        s = cyc + 1;
        push(s, x, y, l, e, g);
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = ~y;
        wait_empty();
    endtask

    initial begin
        int s;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_L", L, 1'b0);
        chk("rst_E", E, 1'b0);
        chk("rst_G", G, 1'b0);
        rst = 1'b1;

        // FFFFFFFF vs 123: unsigned greater, also busy during scan
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'd123;
        sgn = 1'b0;
        start = 1'b1;
        s = cyc + 1;
        push(s, a, b, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_first", busy, 1'b1);
        wait_empty();
        chk("busy_after", busy, 1'b0);

        run_op(32'hFFFF_FFFF, 32'd123, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back equal operands, start held through two captures
        @(negedge clk);
        a = 32'h8000_0001;
        b = 32'h8000_0001;
        sgn = 1'b0;
        start = 1'b1;
        s = cyc + 1;
        push(s, a, b, 1'b0, 1'b1, 1'b0);
        push(s + W + 1, a, b, 1'b0, 1'b1, 1'b0);
        while (cyc < s + W) @(negedge clk);
        sgn = 1'b1;
        while (cyc < s + W + 1) @(negedge clk);
        chk("b2b_busy", busy, 1'b1);
        start = 1'b0;
        wait_empty();

        // start during the scan must be ignored
        @(negedge clk);
        a = 32'd5;
        b = 32'd9;
        sgn = 1'b0;
        start = 1'b1;
        s = cyc + 1;
        push(s, 32'd5, 32'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 9) @(negedge clk);
        a = 32'd100;
        b = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        chk("held_L", L, 1'b1);

        // Asynchronous reset mid-scan clears everything at once
        @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        sgn = 1'b0;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 15) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_L", L, 1'b0);
        chk("async_E", E, 1'b0);
        chk("async_G", G, 1'b0);
        chk("async_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_serial_comparator.md
Name: seq_serial_comparator

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit operands; parametrised successor to the fixed 32-bit unsigned serial comparator.
- Latches parallel operands on a start pulse, serialises them internally (no external shift registers), and compares one bit pair per clock.
- Supports unsigned and two's-complement signed comparison, selected per operation.
- Reports L/E/G with a done pulse; sits beside the ALU/datapath as a low-area compare unit.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64. The counter width is derived internally as clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled high in IDLE or DONE starts an operation
- sgn  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when a result is valid
- L  output  1  A < B
- E  output  1  A == B
- G  output  1  A > B

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; busy = done = L = E = G = 0; operand regs and counter = 0.
  - Takes effect immediately, including mid-SHIFT; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE / DONE, start = 1:
  - Capture a, b, sgn into internal shift regs; count = 0; running result = EQ.
  - Next state SHIFT. From DONE this is back-to-back; no idle cycle is required.
- IDLE, start = 0: stay in IDLE.
- DONE, start = 0: go to IDLE.
- SHIFT, each cycle, default build (LSB-first):
  - Examine bit pair (a_i, b_i) for i = count.
  - If a_i != b_i: running result = GT when a_i = 1, else LT. A later differing bit overrides an earlier one.
  - Sign-bit rule: when sgn = 1 and i = WIDTH-1, the GT/LT decision is inverted.
  - Shift both regs right by one; count++.
  - After the WIDTH-th bit (count = WIDTH-1 processed), next state DONE.
- Entry to DONE:
  - done = 1 for exactly one cycle.
  - L/E/G are loaded from the running result (exactly one of them high).
  - L/E/G hold until the next DONE entry or reset; they do not change during SHIFT.
- Latency (default build): start sampled at edge 0 → done high after edge WIDTH+1. Throughput is one result per WIDTH+1 cycles with start held high.
- start while in SHIFT: ignored; the operand regs are not disturbed.
- a/b/sgn changes after capture: no effect on the operation in progress.
- busy = (state == SHIFT), registered.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined:
  - Scan is MSB-first: shift left, examine bit WIDTH-1-count.
  - The first differing bit decides the result (inverted when it is the sign bit and sgn = 1).
  - Next state is DONE immediately after that bit.
  - Equal operands still take WIDTH SHIFT cycles.
  - done follows start by k+1 edges, where k = 1-based MSB-first index of the first differing bit.
- Undefined: the fixed-latency LSB-first scan described above.
- L/E/G values must be identical in both builds for every input.

Test Plan:
- WIDTH=32, a=32'hFFFFFFFF, b=32'd123, sgn=0, start 1 cycle → busy for 32 cycles; done pulse at edge 33; G=1, L=0, E=0.
- Same operands, sgn=1 → L=1 (-1 < 123); same latency.
- a=b=32'h8000_0001, sgn=0 then sgn=1 back-to-back with start held high → E=1 both times; done pulses 33 edges apart; no IDLE cycle between operations.
- Start at edge 0 (a=5, b=9), then assert start with a=100, b=0 at edge 10 → second request ignored; result L=1 at edge 33; operand regs unchanged.
- Drop rst low mid-SHIFT at edge 15 → all outputs 0 immediately (before the next edge); after release, a new start (a=7, b=7) → E=1 after WIDTH+1 edges.
- SEQ_CMP_EARLY_EXIT_EN, a=32'h8000_0000, b=0:
  - sgn=0 → G=1, done at edge 2.
  - sgn=1 → L=1, done at edge 2.
  - a=b → E=1, done at edge 33.
